// File: rtl/bus_wait_slave_pkg.sv
// Shared types and constants for the AZPR generic wait-state slave.
package bus_wait_slave_pkg;

    // Bus widths: word-addressed 32-bit bus.
    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;

    typedef logic [WORD_ADDR_W-1:0] word_addr_t;
    typedef logic [WORD_DATA_W-1:0] word_data_t;

    // Active-low strobe levels and transfer direction.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    // Slave FSM encodings.
    typedef enum logic [1:0] {
        BUS_WAIT_SLAVE_IDLE = 2'd0,
        BUS_WAIT_SLAVE_WAIT = 2'd1,
        BUS_WAIT_SLAVE_ACK  = 2'd2
    } wait_slave_state_t;

    // Register index taken from the low word-address bits.
    localparam int WAIT_SLAVE_REG_INDEX_LOC = 0;
    typedef logic [2:0] wait_slave_reg_index_t;
    localparam wait_slave_reg_index_t WAIT_SLAVE_ID_REG = 3'd7;

    // Wait counter width (WAIT_CYCLES legal range 0..15).
    localparam int WAIT_CNT_W = 4;

    // Extract the decoded register index; upper address bits are don't-care.
    function automatic wait_slave_reg_index_t reg_index(input word_addr_t a);
        return a[WAIT_SLAVE_REG_INDEX_LOC +: 3];
    endfunction

endpackage

// File: rtl/bus_wait_slave_if.sv
// Slave-side bus signals between decoder/master and a wait-state slave.
interface bus_wait_slave_if;
    import bus_wait_slave_pkg::*;

    logic       cs_;
    logic       as_;
    logic       rw;
    word_addr_t addr;
    word_data_t wr_data;
    word_data_t rd_data;
    logic       rdy_;

    modport master (
        output cs_, as_, rw, addr, wr_data,
        input  rd_data, rdy_
    );

    modport slave (
        input  cs_, as_, rw, addr, wr_data,
        output rd_data, rdy_
    );
endinterface

// File: rtl/bus_wait_slave.sv
// Generic AZPR bus slave: seven R/W word registers plus a read-only ID
// register, answering each access after WAIT_CYCLES extra wait states.
module bus_wait_slave
    import bus_wait_slave_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter word_data_t  ID_VALUE    = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    bus_wait_slave_if.slave  bus
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);
    localparam int NUM_RW_REGS = 7;

    wait_slave_state_t      state_reg, state_next;
    logic [WAIT_CNT_W-1:0]  cnt_reg, cnt_next;
    wait_slave_reg_index_t  idx_reg, idx_next;
    logic                   rw_reg, rw_next;
    word_data_t             wdata_reg, wdata_next;

    word_data_t             regs [NUM_RW_REGS];
    word_data_t             rd_data_reg;
    logic                   rdy_reg;

    logic                   enter_ack;
    logic                   wr_en;
    word_data_t             rd_value;

    // Next-state logic: accept in IDLE, count down in WAIT, one-cycle ACK.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        rw_next    = rw_reg;
        wdata_next = wdata_reg;
        case (state_reg)
            BUS_WAIT_SLAVE_IDLE: begin
                if (bus.cs_ == ENABLE_ && bus.as_ == ENABLE_) begin
                    idx_next   = reg_index(bus.addr);
                    rw_next    = bus.rw;
                    wdata_next = bus.wr_data;
                    cnt_next   = WAIT_LOAD;
                    state_next = (WAIT_LOAD != '0) ? BUS_WAIT_SLAVE_WAIT
                                                   : BUS_WAIT_SLAVE_ACK;
                end
            end
            BUS_WAIT_SLAVE_WAIT: begin
                // Master withdrawing the request cancels it silently.
                if (bus.cs_ == DISABLE_ || bus.as_ == DISABLE_) begin
                    state_next = BUS_WAIT_SLAVE_IDLE;
                end else begin
                    // Counter reaches 0 only on the way out, so it never wraps.
                    cnt_next = cnt_reg - 1'b1;
                    if (cnt_reg == WAIT_CNT_W'(1))
                        state_next = BUS_WAIT_SLAVE_ACK;
                end
            end
            BUS_WAIT_SLAVE_ACK: begin
                state_next = BUS_WAIT_SLAVE_IDLE;
            end
            default: begin
                state_next = BUS_WAIT_SLAVE_IDLE;
            end
        endcase
    end

    // Access completes on the edge that enters ACK; use the *_next view so a
    // zero-wait access served straight from IDLE sees the fresh request.
    always_comb begin
        enter_ack = (state_next == BUS_WAIT_SLAVE_ACK) && (state_reg != BUS_WAIT_SLAVE_ACK);
        wr_en     = enter_ack && (rw_next == WRITE) && (idx_next != WAIT_SLAVE_ID_REG);
        rd_value  = (idx_next == WAIT_SLAVE_ID_REG) ? ID_VALUE : regs[idx_next];
    end

    // FSM and request-latch registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= BUS_WAIT_SLAVE_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            rw_reg    <= READ;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            rw_reg    <= rw_next;
            wdata_reg <= wdata_next;
        end
    end

    // Register file: writes to the ID slot are dropped (wr_en excludes it).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_RW_REGS; i++)
                regs[i] <= '0;
        end else if (wr_en) begin
            regs[idx_next] <= wdata_next;
        end
    end

    // Registered outputs: rdy_ pulses for the ACK cycle, rd_data is 0 otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_reg     <= DISABLE_;
            rd_data_reg <= '0;
        end else begin
            rdy_reg     <= enter_ack ? ENABLE_ : DISABLE_;
            rd_data_reg <= (enter_ack && rw_next == READ) ? rd_value : '0;
        end
    end

    assign bus.rdy_    = rdy_reg;
    assign bus.rd_data = rd_data_reg;

endmodule

// File: tb/tb_bus_wait_slave.sv
// Self-checking bench: three slaves (0, 3 and 4 wait states) share one
// master; a register-array model predicts every rdy_/rd_data cycle.
module tb_bus_wait_slave;
    import bus_wait_slave_pkg::*;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NDUT-1:0] cs_n;
    logic            as_n;
    logic            rw_s;
    word_addr_t      addr_s;
    word_data_t      wdata_s;
    word_data_t      rd_v [NDUT];
    logic [NDUT-1:0] rdy_v;

    bus_wait_slave_if bus0 ();
    bus_wait_slave_if bus1 ();
    bus_wait_slave_if bus2 ();

    assign bus0.cs_ = cs_n[0];  assign bus1.cs_ = cs_n[1];  assign bus2.cs_ = cs_n[2];
    assign bus0.as_ = as_n;     assign bus1.as_ = as_n;     assign bus2.as_ = as_n;
    assign bus0.rw  = rw_s;     assign bus1.rw  = rw_s;     assign bus2.rw  = rw_s;
    assign bus0.addr = addr_s;  assign bus1.addr = addr_s;  assign bus2.addr = addr_s;
    assign bus0.wr_data = wdata_s; assign bus1.wr_data = wdata_s; assign bus2.wr_data = wdata_s;
    assign rd_v[0] = bus0.rd_data; assign rd_v[1] = bus1.rd_data; assign rd_v[2] = bus2.rd_data;
    assign rdy_v = {bus2.rdy_, bus1.rdy_, bus0.rdy_};

    bus_wait_slave #(.WAIT_CYCLES(0), .ID_VALUE(32'hA5A5_0001))
        u_dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    bus_wait_slave #(.WAIT_CYCLES(3), .ID_VALUE(32'hA5A5_0003))
        u_dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
    bus_wait_slave #(.WAIT_CYCLES(4), .ID_VALUE(32'hA5A5_0004))
        u_dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

    int n_checks = 0;
    int n_pass   = 0;
    int n_txn    = 0;

    word_data_t model [NDUT][8];

    function automatic int wait_of(input int s);
        case (s)
            0:       return 0;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic word_data_t id_of(input int s);
        case (s)
            0:       return 32'hA5A5_0001;
            1:       return 32'hA5A5_0003;
            default: return 32'hA5A5_0004;
        endcase
    endfunction

    function automatic word_data_t exp_read(input int s, input int idx);
        return (idx == 7) ? id_of(s) : model[s][idx];
    endfunction

    task automatic check_val(input string tag, input word_data_t got, input word_data_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic clear_model();
        for (int s = 0; s < NDUT; s++)
            for (int i = 0; i < 8; i++)
                model[s][i] = '0;
    endtask

    // One master access to slave s. abort_at >= 0 releases cs_/as_ after
    // the cycle k=abort_at (k counts cycles after the sampling edge).
    task automatic access(input int s, input bit is_read, input word_addr_t a,
                          input word_data_t d, input int abort_at);
        int         w;
        int         idx;
        word_data_t exp_rd;
        logic       exp_rdy;
        w      = wait_of(s);
        idx    = int'(a[2:0]);
        exp_rd = is_read ? exp_read(s, idx) : '0;
        @(negedge clk);
        cs_n[s] = 1'b0; as_n = 1'b0; rw_s = is_read; addr_s = a; wdata_s = d;
        for (int k = 0; k <= w + 1; k++) begin
            @(negedge clk);
            exp_rdy = (abort_at < 0 && k == w) ? 1'b0 : 1'b1;
            check_val($sformatf("rdy dut%0d k%0d", s, k), {31'd0, rdy_v[s]}, {31'd0, exp_rdy});
            if (!(exp_rdy == 1'b0 && !is_read))
                check_val($sformatf("rd_data dut%0d k%0d", s, k), rd_v[s],
                          (exp_rdy == 1'b0) ? exp_rd : 32'h0);
            if ((abort_at >= 0 && k == abort_at) || (abort_at < 0 && k == w)) begin
                cs_n = '1; as_n = 1'b1;
            end
        end
        if (!is_read && abort_at < 0 && idx != 7)
            model[s][idx] = d;
        n_txn++;
        $display("txn %0d dut%0d %s addr=%h idx=%0d wdata=%h exp_rd=%h %s", n_txn, s,
                 is_read ? "RD" : "WR", a, idx, d, exp_rd, (abort_at >= 0) ? "aborted" : "done");
    endtask

    // Start a write to slave s, then pull reset while it is still waiting.
    task automatic reset_mid_write(input int s, input word_addr_t a, input word_data_t d);
        @(negedge clk);
        cs_n[s] = 1'b0; as_n = 1'b0; rw_s = WRITE; addr_s = a; wdata_s = d;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("rdy in reset", {31'd0, rdy_v[s]}, 32'd1);
        check_val("rd_data in reset", rd_v[s], 32'h0);
        @(negedge clk);
        cs_n = '1; as_n = 1'b1;
        check_val("rdy held in reset", {31'd0, rdy_v[s]}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        clear_model();
        n_txn++;
        $display("txn %0d dut%0d WR addr=%h wdata=%h reset-abandoned", n_txn, s, a, d);
    endtask

    initial begin
        int s, w, ab;
        cs_n = '1; as_n = 1'b1; rw_s = READ; addr_s = '0; wdata_s = '0;
        reset = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check_val($sformatf("reset rdy dut%0d", i), {31'd0, rdy_v[i]}, 32'd1);
            check_val($sformatf("reset rd_data dut%0d", i), rd_v[i], 32'h0);
        end
        reset = 1'b1;

        // All registers read back as zero, index 7 as the ID.
        for (int i = 0; i < NDUT; i++)
            for (int r = 0; r < 8; r++)
                access(i, READ, word_addr_t'(r), '0, -1);

        // Zero-wait write then read.
        access(0, WRITE, 30'd3, 32'hDEAD_BEEF, -1);
        access(0, READ,  30'd3, '0, -1);
        // Three-wait read.
        access(1, READ,  30'd5, '0, -1);
        // Abort on a four-wait slave leaves the old value.
        access(2, WRITE, 30'd2, 32'h1111_2222, -1);
        access(2, WRITE, 30'd2, 32'h1234_5678, 1);
        access(2, READ,  30'd2, '0, -1);
        // ID register ignores writes; upper address bits alias.
        access(1, WRITE, 30'd7, 32'hFFFF_FFFF, -1);
        access(1, READ,  30'd7, '0, -1);
        access(0, WRITE, 30'h8, 32'hCAFE_F00D, -1);
        access(0, READ,  30'd0, '0, -1);
        access(0, READ,  30'h3FFF_FFF8, '0, -1);
        // Reset during WAIT: nothing written, FSM idle afterwards.
        reset_mid_write(2, 30'd4, 32'h5555_AAAA);
        access(2, READ, 30'd4, '0, -1);
        access(0, READ, 30'd3, '0, -1);

        // Randomized traffic.
        for (int t = 0; t < 200; t++) begin
            s  = int'($urandom_range(0, NDUT - 1));
            w  = wait_of(s);
            ab = -1;
            if (w > 0 && $urandom_range(0, 5) == 0)
                ab = int'($urandom_range(0, w - 1));
            access(s, 1'($urandom_range(0, 1)), word_addr_t'($urandom), word_data_t'($urandom), ab);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Final sweep of every register against the model.
        for (int i = 0; i < NDUT; i++)
            for (int r = 0; r < 8; r++)
                access(i, READ, word_addr_t'(r), '0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
